// File: rtl/kpg_prefix_adder_pipe_pkg.sv
// Shared KPG (kill/propagate/generate) encoding and cell functions used by
// the prefix levels and the top-level adder pipeline.
package kpg_pkg;

  typedef logic [1:0] kpg_t;

  localparam kpg_t KPG_K = 2'b00;
  localparam kpg_t KPG_P = 2'b01;
  localparam kpg_t KPG_G = 2'b11;

  // Single-bit cell: both set -> G, exactly one set -> P, none -> K.
  // {a&b, a|b} yields exactly those three codes and never 2'b10.
  function automatic kpg_t kpg_cell(input logic a, input logic b);
    return {a & b, a | b};
  endfunction

  // Prefix combine (hi o lo): a propagating upper group defers to the lower one.
  function automatic kpg_t kpg_combine(input kpg_t hi, input kpg_t lo);
    return (hi == KPG_P) ? lo : hi;
  endfunction

endpackage

// File: rtl/kpg_prefix_level.sv
// One combinational Kogge-Stone level over N KPG cells with span DIST.
// Positions below DIST have no partner and pass through unchanged.
module kpg_prefix_level
  import kpg_pkg::*;
#(
  parameter int N    = 33,
  parameter int DIST = 1
) (
  input  kpg_t [N-1:0] din,
  output kpg_t [N-1:0] dout
);

  // Combine every position with the one DIST below it.
  always_comb begin
    dout = din;
    for (int i = DIST; i < N; i++) begin
      dout[i] = kpg_combine(din[i], din[i-DIST]);
    end
  end

endmodule

// File: rtl/kpg_prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder on KPG cells. Position 0 of the prefix vector is
// the carry-in cell; position i+1 is operand bit i. After the prefix, position i
// is G exactly when the carry into bit i is 1. A single global enable stalls
// every stage together when the output is held by the consumer.
module kpg_prefix_adder_pipe
  import kpg_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N = WIDTH + 1;
  localparam int L = $clog2(WIDTH + 1);
  localparam int S = (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  // Index of the last prefix level feeding prefix stage register s (s >= 1).
  function automatic int stage_src(input int s);
    int top;
    top = s * LEVELS_PER_STAGE;
    if (top > L) top = L;
    return top - 1;
  endfunction

  kpg_t [N-1:0]     cells;
  kpg_t [N-1:0]     stg_p   [0:S];
  logic [WIDTH-1:0] xor_p   [0:S];
  logic             vld_p   [0:S];
  kpg_t [N-1:0]     lvl_in  [0:L-1];
  kpg_t [N-1:0]     lvl_out [0:L-1];
  logic [N-1:0]     carry;
  logic             en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Bit cells for the operands plus the carry-in cell at position 0.
  always_comb begin
    cells[0] = cin ? KPG_G : KPG_K;
    for (int i = 0; i < WIDTH; i++) begin
      cells[i+1] = kpg_cell(a[i], b[i]);
    end
  end

  // Prefix levels; a level starting a new stage reads that stage's register.
  for (genvar j = 0; j < L; j++) begin : g_lvl
    if (j % LEVELS_PER_STAGE == 0) begin : g_reg_in
      assign lvl_in[j] = stg_p[j / LEVELS_PER_STAGE];
    end else begin : g_comb_in
      assign lvl_in[j] = lvl_out[j-1];
    end
    kpg_prefix_level #(
      .N    (N),
      .DIST (1 << j)
    ) u_level (
      .din  (lvl_in[j]),
      .dout (lvl_out[j])
    );
  end

  // Data pipeline: stage 0 captures cells and operand XOR, stages 1..S the prefix.
  always_ff @(posedge clk) begin
    if (en) begin
      stg_p[0] <= cells;
      xor_p[0] <= a ^ b;
      for (int s = 1; s <= S; s++) begin
        stg_p[s] <= lvl_out[stage_src(s)];
        xor_p[s] <= xor_p[s-1];
      end
    end
  end

  // Valid chain alongside the data; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s <= S; s++) vld_p[s] <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      vld_p[0] <= in_valid;
      for (int s = 1; s <= S; s++) vld_p[s] <= vld_p[s-1];
      out_valid <= vld_p[S];
    end
  end

  // Resolved prefix: G (bit 1 set) means carry into that position's bit.
  always_comb begin
    for (int i = 0; i < N; i++) carry[i] = stg_p[S][i][1];
  end

  // Registered result: sum, carry out, and signed overflow from MSB carries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (en) begin
      sum      <= xor_p[S] ^ carry[WIDTH-1:0];
      cout     <= carry[WIDTH];
      overflow <= carry[WIDTH-1] ^ carry[WIDTH];
    end
  end

endmodule

// File: tb/tb_kpg_prefix_adder_pipe.sv
// Self-checking bench: directed tests on a 32-bit / 2-levels-per-stage instance
// plus a randomized sweep over several widths and stage groupings.
module tb_kpg_prefix_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int sweep_done = 0;
  logic sw_rst_n = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer addition, signed overflow from operand/result signs.
  function automatic logic [63:0] exp_add(input int w, input logic [63:0] x,
                                          input logic [63:0] y, input logic c);
    logic [63:0] m, t, s;
    logic co, ov;
    m  = (64'd1 << w) - 64'd1;
    t  = (x & m) + (y & m) + {63'd0, c};
    s  = t & m;
    co = t[w];
    ov = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
    return s | ({63'd0, co} << w) | ({63'd0, ov} << (w + 1));
  endfunction

  function automatic logic [63:0] pack_obs(input int w, input logic [63:0] s,
                                           input logic co, input logic ov);
    return s | ({63'd0, co} << w) | ({63'd0, ov} << (w + 1));
  endfunction

  // ---------------- main 32-bit instance ----------------
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0, sum;
  logic        cin = 1'b0, cout, overflow;

  kpg_prefix_adder_pipe #(.WIDTH(32), .LEVELS_PER_STAGE(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  // Send one operation with out_ready=1; lat counts edges from the accept edge (=1).
  task automatic run_one(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tc, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  logic [31:0] a4 [8];
  logic [31:0] b4 [8];
  logic        c4 [8];

  initial begin
    int lat, sent, recv, cyc;
    logic [63:0] held;
    logic [63:0] exp4 [8];

    // 1. reset with in_valid asserted
    rst_n = 1'b0; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // 2. full carry ripple
    run_one(32'hFFFF_FFFF, 32'h0, 1'b1, lat);
    chk("ripple_latency", 64'(lat), 64'd5);
    chk("ripple_sum", {32'd0, sum}, 64'd0);
    chk("ripple_cout", {63'd0, cout}, 64'd1);
    chk("ripple_ovf", {63'd0, overflow}, 64'd0);

    // 3. signed overflow corners
    run_one(32'h7FFF_FFFF, 32'h1, 1'b0, lat);
    chk("ovf1_sum", {32'd0, sum}, 64'h8000_0000);
    chk("ovf1_cout", {63'd0, cout}, 64'd0);
    chk("ovf1_ovf", {63'd0, overflow}, 64'd1);
    run_one(32'h8000_0000, 32'h8000_0000, 1'b0, lat);
    chk("ovf2_sum", {32'd0, sum}, 64'd0);
    chk("ovf2_cout", {63'd0, cout}, 64'd1);
    chk("ovf2_ovf", {63'd0, overflow}, 64'd1);
    @(negedge clk);

    // 4. back-to-back stream with a 4-cycle output stall
    for (int i = 0; i < 8; i++) begin
      a4[i] = $urandom; b4[i] = $urandom; c4[i] = 1'($urandom_range(1));
      exp4[i] = exp_add(32, {32'd0, a4[i]}, {32'd0, b4[i]}, c4[i]);
    end
    sent = 0; recv = 0; cyc = 0; held = '0;
    while (recv < 8 && cyc < 60) begin
      @(negedge clk);
      in_valid = (sent < 8);
      if (sent < 8) begin a = a4[sent]; b = b4[sent]; cin = c4[sent]; end
      out_ready = !(cyc >= 5 && cyc < 9);
      #1;
      if (!out_ready) begin
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        if (cyc == 5) held = pack_obs(32, {32'd0, sum}, cout, overflow);
        else chk("stall_hold", pack_obs(32, {32'd0, sum}, cout, overflow), held);
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
      end
      if (out_valid && out_ready) begin
        chk("stream_result", pack_obs(32, {32'd0, sum}, cout, overflow), exp4[recv]);
        recv++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    chk("stream_count", 64'(recv), 64'd8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("stream_no_dup", {63'd0, out_valid}, 64'd0);
    end

    // 5. reset while three operations are in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_out", {63'd0, out_valid}, 64'd0);
    end
    run_one(32'd1234, 32'd4321, 1'b1, lat);
    chk("midrst_latency", 64'(lat), 64'd5);
    chk("midrst_sum", pack_obs(32, {32'd0, sum}, cout, overflow),
        exp_add(32, 64'd1234, 64'd4321, 1'b1));

    // 6. wait for the parameter sweep
    cyc = 0;
    while (sweep_done < 12 && cyc < 40000) begin
      @(posedge clk);
      cyc++;
    end
    chk("sweep_finished", 64'(sweep_done), 64'd12);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    sw_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sw_rst_n = 1'b1;
  end

  // ---------------- parameter sweep instances ----------------
  for (genvar g = 0; g < 12; g++) begin : g_sweep
    localparam int W   = (g / 3 == 0) ? 2 : (g / 3 == 1) ? 8 : (g / 3 == 2) ? 32 : 53;
    localparam int LPS = (g % 3 == 0) ? 1 : (g % 3 == 1) ? 2 : 4;
    localparam int LL  = $clog2(W + 1);
    localparam int SS  = (LL + LPS - 1) / LPS;

    logic         s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1;
    logic [W-1:0] s_a = '0, s_b = '0, s_sum;
    logic         s_cin = 1'b0, s_cout, s_ovf;
    logic [63:0]  q [$];

    kpg_prefix_adder_pipe #(.WIDTH(W), .LEVELS_PER_STAGE(LPS)) u_dut (
      .clk(clk), .rst_n(sw_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .a(s_a), .b(s_b), .cin(s_cin), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .sum(s_sum), .cout(s_cout), .overflow(s_ovf)
    );

    initial begin
      int lat, pushes, cyc;
      logic [63:0] r, obs, ea;
      string tag;
      tag = $sformatf("sweep_w%0d_l%0d", W, LPS);
      wait (sw_rst_n === 1'b1);
      // latency of a single isolated operation
      @(negedge clk);
      r = {$urandom, $urandom}; s_a = r[W-1:0];
      r = {$urandom, $urandom}; s_b = r[W-1:0];
      s_cin = 1'b1; s_in_valid = 1'b1; s_out_ready = 1'b1;
      ea = exp_add(W, 64'(s_a), 64'(s_b), s_cin);
      @(posedge clk);
      lat = 1;
      #1 s_in_valid = 1'b0;
      while (!s_out_valid && lat < 20) begin
        @(posedge clk);
        lat++;
        #1;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(SS + 2));
      chk({tag, "_first"}, pack_obs(W, 64'(s_sum), s_cout, s_ovf), ea);
      @(posedge clk);
      // random traffic with random backpressure
      pushes = 0; cyc = 0;
      while (pushes < 1000 && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        s_in_valid  = ($urandom_range(3) != 0);
        s_out_ready = ($urandom_range(3) != 0);
        r = {$urandom, $urandom}; s_a = r[W-1:0];
        r = {$urandom, $urandom}; s_b = r[W-1:0];
        s_cin = 1'($urandom_range(1));
        #1;
        if (s_out_valid && s_out_ready) begin
          obs = pack_obs(W, 64'(s_sum), s_cout, s_ovf);
          if (q.size() == 0) chk({tag, "_extra"}, obs, 64'hDEAD_0000_0000_0000);
          else chk(tag, obs, q.pop_front());
        end
        if (s_in_valid && s_in_ready) begin
          q.push_back(exp_add(W, 64'(s_a), 64'(s_b), s_cin));
          pushes++;
        end
      end
      // drain
      cyc = 0;
      while (q.size() != 0 && cyc < 50) begin
        @(negedge clk);
        cyc++;
        s_in_valid = 1'b0; s_out_ready = 1'b1;
        #1;
        if (s_out_valid) chk(tag, pack_obs(W, 64'(s_sum), s_cout, s_ovf), q.pop_front());
      end
      chk({tag, "_drained"}, 64'(q.size()), 64'd0);
      sweep_done++;
    end
  end

endmodule
